kalman_gain_2x2: RTL

// Consumes the 2x2 inverse produced by the matrix-inversion stage and forms the Kalman gain K = P * Sinv.
// P is the 2x2 predicted covariance (H = I); all operands are signed fixed-point with intDigits integer bits.
// One shared multiply-accumulate is sequenced by an FSM, element by element, under the MATLAB clock-enable.

---
 rtl/kalman_pkg.sv | 41 ++++
 rtl/kalman_gain_2x2_mac.sv | 49 ++++
 rtl/kalman_gain_2x2.sv | 104 ++++++++++
 3 files changed

// File: rtl/kalman_pkg.sv
// Shared types and fixed-point helpers for the Kalman filter pipeline.
// Used by the inverter, gain and state-update stages.
package kalman_pkg;

  localparam int DATA_W = 16;
  localparam int INT_DIGITS = 10;
  localparam int FRAC = DATA_W - INT_DIGITS;
  localparam int ACC_W = 2 * DATA_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    STORE,
    DONE
  } gain_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              ovf;
  } sat_t;

  // Floor-shift out the fraction, then clamp to the element range.
  function automatic sat_t sat_fx(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    logic [ACC_W-DATA_W:0]   hi;
    sat_t                    r;
    sh = acc >>> FRAC;
    hi = sh[ACC_W-1:DATA_W-1];
    r.ovf = !((&hi) || !(|hi));
    if (!r.ovf) begin
      r.val = sh[DATA_W-1:0];
    end else if (sh[ACC_W-1]) begin
      r.val = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      r.val = {1'b0, {(DATA_W-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/kalman_gain_2x2_mac.sv
// Shared signed multiply-accumulate with floor shift and saturation.
// clr selects a fresh product instead of accumulating.
module fx_mac_sat #(
  parameter int WIDTH = 16,
  parameter int intDigits = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] q,
  output logic                    ovf
);

  localparam int FSH = WIDTH - intDigits;
  localparam int AW = 2 * WIDTH + 1;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      prod_x;
  logic signed [AW-1:0]      acc;
  logic signed [AW-1:0]      sh;
  logic [AW-WIDTH:0]         hi;

  assign prod = a * b;
  assign prod_x = {prod[2*WIDTH-1], prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? prod_x : acc + prod_x;
    end
  end

  assign sh = acc >>> FSH;
  assign hi = sh[AW-1:WIDTH-1];
  assign ovf = !((&hi) || !(|hi));

  always_comb begin
    q = sh[WIDTH-1:0];
    if (ovf) begin
      q = sh[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/kalman_gain_2x2.sv
// Kalman gain stage: K = P * Sinv for 2x2 fixed-point matrices,
// one element at a time on a single shared MAC.
module kalman_gain_2x2
  import kalman_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int intDigits = INT_DIGITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        startGain,
  input  logic [1:0][1:0][WIDTH-1:0]  P,
  input  logic [1:0][1:0][WIDTH-1:0]  Sinv,
  output logic [1:0][1:0][WIDTH-1:0]  K,
  output logic                        endGain,
  output logic                        busy,
  output logic                        satFlag
);

  gain_state_t state, state_nx;

  logic [1:0]                  idx;
  logic                        ii, jj;
  logic [1:0][1:0][WIDTH-1:0]  p_q, s_q;
  logic                        mac_en, mac_clr, ovf;
  logic signed [WIDTH-1:0]     a_op, b_op, q;

  assign ii = idx[1];
  assign jj = idx[0];

  always_comb begin
    state_nx = state;
    mac_en = 1'b0;
    mac_clr = 1'b0;
    a_op = p_q[ii][0];
    b_op = s_q[0][jj];
    case (state)
      IDLE: begin
        if (startGain) state_nx = MUL0;
      end
      MUL0: begin
        mac_en = 1'b1;
        mac_clr = 1'b1;
        state_nx = MUL1;
      end
      MUL1: begin
        mac_en = 1'b1;
        a_op = p_q[ii][1];
        b_op = s_q[1][jj];
        state_nx = STORE;
      end
      STORE: begin
        state_nx = (idx == 2'd3) ? DONE : MUL0;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      K <= '0;
      p_q <= '0;
      s_q <= '0;
      satFlag <= 1'b0;
    end else if (clk_en) begin
      state <= state_nx;
      if (state == IDLE && startGain) begin
        p_q <= P;
        s_q <= Sinv;
        satFlag <= 1'b0;
      end
      // idx wraps 3 -> 0, ready for the next request
      if (state == STORE) begin
        K[ii][jj] <= q;
        satFlag <= satFlag | ovf;
        idx <= idx + 2'd1;
      end
    end
  end

  fx_mac_sat #(
    .WIDTH(WIDTH),
    .intDigits(intDigits)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .en(mac_en & clk_en),
    .clr(mac_clr),
    .a(a_op),
    .b(b_op),
    .q(q),
    .ovf(ovf)
  );

  assign endGain = (state == DONE);
  assign busy = (state != IDLE);

endmodule
